// File: rtl/riscboy_uart_tx.sv
// rtl/riscboy_uart_tx.sv - 8N1 UART transmitter with TX FIFO and integer+fractional baud divider
// Optional flow control: define UART_TX_CTS_EN to add the synchronised cts_n input.
module riscboy_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_INT_W  = 12,
    parameter int DIV_FRAC_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_INT_W-1:0]          div_int,
    input  logic [DIV_FRAC_W-1:0]         div_frac,
    input  logic [7:0]                    wdata,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
`ifdef UART_TX_CTS_EN
    ,
    input  logic                          cts_n
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = DIV_INT_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_next;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         div_eff;
    logic [DIV_FRAC_W-1:0] acc;
    logic [DIV_FRAC_W:0]   frac_sum;
    logic [7:0]            shreg;
    logic [2:0]            bit_idx;
    logic                  clear_to_send, can_pop, bit_end;
    logic                  load, shift, acc_clr, tx_next;

    assign wready = (level != LW'(FIFO_DEPTH));
    assign push   = wvalid && wready;
    assign busy   = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
        end
    end
    assign clear_to_send = !cts_sync[1];
`else
    assign clear_to_send = 1'b1;
`endif

    assign can_pop  = (level != '0) && enable && clear_to_send;
    assign bit_end  = (cnt == CW'(1));
    // The fractional accumulator's carry stretches a bit by one cycle.
    assign frac_sum = {1'b0, acc} + {1'b0, div_frac};
    assign div_eff  = (div_int == '0) ? CW'(1) : {1'b0, div_int};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        acc_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    load       = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    load  = 1'b1;
                    shift = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (can_pop) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        acc_clr    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            if (load) begin
                cnt <= div_eff + CW'(frac_sum[DIV_FRAC_W]);
                acc <= frac_sum[DIV_FRAC_W-1:0];
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (acc_clr) acc <= '0;
            if (pop) begin
                shreg <= mem[rd_ptr];
            end else if (shift) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (shift) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // Line is registered from the current state, so it trails the FSM by one cycle.
            tx <= tx_next;
        end
    end
endmodule

// File: tb/tb_riscboy_uart_tx.sv
// tb/tb_riscboy_uart_tx.sv - self-checking bench for riscboy_uart_tx with a frame-level line model
module tb_riscboy_uart_tx;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] div_int = 12'd4;
    logic [3:0]  div_frac = 4'd0;
    logic [7:0]  wdata = 8'd0;
    logic        wvalid = 1'b0;
    logic        wready, busy, tx;
    logic [3:0]  level;
`ifdef UART_TX_CTS_EN
    logic        cts_n = 1'b1;
`endif

    riscboy_uart_tx dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div_int(div_int), .div_frac(div_frac),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .level(level), .busy(busy), .tx(tx)
`ifdef UART_TX_CTS_EN
        , .cts_n(cts_n)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus a queue of future line values, one per cycle.
    byte unsigned m_fifo[$];
    bit           m_txq[$];
    int           m_rem, m_acc, m_level;
    bit           m_tx, m_cts1, m_cts2;

    function automatic int frame_len(input int di, input int df, input int acc0);
        int a = acc0;
        int t = 0;
        for (int k = 0; k < 10; k++) begin
            a = a + df;
            t += ((di == 0) ? 1 : di) + (a >> 4);
            a = a & 15;
        end
        return t;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_txq.delete();
        m_rem = 0; m_acc = 0; m_level = 0; m_tx = 1'b1;
        m_cts1 = 1'b1; m_cts2 = 1'b1;
    endtask

    task automatic model_step();
        bit do_push, do_pop, cts_ok;
        byte unsigned b;
        int di, p;
        do_push = wvalid && (m_fifo.size() != DEPTH);
`ifdef UART_TX_CTS_EN
        cts_ok = !m_cts2;
        m_cts2 = m_cts1;
        m_cts1 = cts_n;
`else
        cts_ok = 1'b1;
`endif
        do_pop = (m_rem <= 1) && (m_fifo.size() > 0) && enable && cts_ok;
        m_tx = (m_txq.size() > 0) ? m_txq.pop_front() : 1'b1;
        if (m_rem > 0) m_rem--;
        if (m_rem == 0 && !do_pop) m_acc = 0;
        if (do_pop) begin
            b  = m_fifo.pop_front();
            di = (div_int == 0) ? 1 : int'(div_int);
            m_rem = 0;
            for (int k = 0; k < 10; k++) begin
                m_acc = m_acc + int'(div_frac);
                p = di + (m_acc >> 4);
                m_acc = m_acc & 15;
                m_rem += p;
                repeat (p) m_txq.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
            end
        end
        if (do_push) m_fifo.push_back(wdata);
        m_level = m_fifo.size();
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("cyc_tx", tx, m_tx);
        check("cyc_level", level, m_level);
        check("cyc_wready", wready, m_level != DEPTH);
        check("cyc_busy", busy, (m_rem > 0) || (m_level > 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wdata  = d;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int n;
        int pat[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [7:0] rx;

        check("len_4p5", frame_len(4, 8, 0), 45);
        check("len_434", frame_len(434, 0, 0), 4340);

        repeat (10) begin
            tick();
            check("rst_tx", tx, 1);
            check("rst_wready", wready, 1);
            check("rst_level", level, 0);
            check("rst_busy", busy, 0);
        end
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);

        // Single byte at 115200 baud from 50 MHz
        enable = 1'b1; div_int = 12'd434; div_frac = 4'd0;
        write_byte(8'h55);
        tick();
        check("lat_edge1_tx", tx, 1);
        tick();
        check("lat_edge2_tx", tx, 0);
        repeat (217) tick();
        check("b55_bit0", tx, pat[0]);
        for (int i = 1; i < 10; i++) begin
            repeat (434) tick();
            check($sformatf("b55_bit%0d", i), tx, pat[i]);
            if (i >= 1 && i <= 8) rx[i-1] = tx;
        end
        check("b55_rx", rx, 8'h55);
        wait_idle("b55_idle", 500, n);

        // Fractional 4.5 cycles per bit
        div_int = 12'd4; div_frac = 4'd8;
        write_byte(8'hA3);
        wait_idle("frac_idle", 200, n);
        check("frac_len", n - 1, 45);
        repeat (3) tick();

        // Full FIFO, then back-to-back drain
        enable = 1'b0; div_frac = 4'd0;
        for (int i = 0; i < 9; i++) begin
            wdata = 8'(i); wvalid = 1'b1;
            tick();
            if (i == 7) begin
                check("full_wready", wready, 0);
                check("full_level8", level, 8);
            end
        end
        wvalid = 1'b0;
        check("full_drop_level", level, 8);
        enable = 1'b1;
        wait_idle("drain_idle", 1000, n);
        check("drain_len", n, 321);
        repeat (3) tick();

        // Disable mid-frame, then reset mid-frame
        for (int i = 0; i < 3; i++) begin
            wdata = 8'hC0 + 8'(i); wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0;
        repeat (13) tick();
        enable = 1'b0;
        repeat (60) tick();
        check("dis_tx", tx, 1);
        check("dis_level", level, 2);
        check("dis_busy", busy, 1);
        enable = 1'b1;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_level", level, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wready", wready, 1);

`ifdef UART_TX_CTS_EN
        cts_n = 1'b1;
        repeat (4) tick();
        write_byte(8'h41);
        repeat (20) tick();
        check("cts_hold_tx", tx, 1);
        check("cts_hold_level", level, 1);
        cts_n = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("cts_start_seen", tx, 0);
        check("cts_start_le4", n <= 4, 1);
        wait_idle("cts_idle", 200, n);
`endif

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscboy_uart_tx.md
# riscboy_uart_tx

Transmit half of the RISCBoy UART: accepts bytes from the processor bus through a valid/ready write port, buffers them in a small FIFO, and serialises them 8N1 (LSB first, one stop bit) onto a single pin at a programmable baud rate. Its `tx` output drives the GPIO pad monitored by the system-level behavioural UART receiver. It therefore sits directly upstream of that receiver. The bit period is derived from the system clock by an integer+fractional divider, so 115200 baud is reachable from the 50 MHz core clock.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, minimum 2.
- `DIV_INT_W`, default 12: width of integer divisor.
- `DIV_FRAC_W`, default 4: width of fractional divisor (units of 1/2^DIV_FRAC_W cycle).
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: transmitter enable; FIFO writes are accepted regardless.
- `div_int` input DIV_INT_W: integer cycles per bit; 0 is treated as 1.
- `div_frac` input DIV_FRAC_W: fractional cycles per bit.
- `wdata` input 8: byte to enqueue.
- `wvalid` input 1: write request.
- `wready` output 1: FIFO not full.
- `level` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `busy` output 1: a frame is in progress or the FIFO is non-empty.
- `tx` output 1: serial line, idle high.
- `cts_n` input 1: clear-to-send, active-low. Present only with UART_TX_CTS_EN.

## Operation
- The write handshake is `wvalid && wready`, with `wready = (level != FIFO_DEPTH)`. A write while full is dropped, and `level` is unchanged.
- FSM states: IDLE, START, DATA, STOP.
- In IDLE, the FIFO is popped when it is non-empty and `enable` is high (and `cts_n` is low if CTS is compiled in). The popped byte loads an 8-bit shift register and the FSM enters START.
- START drives `tx`=0 for one bit period, then the FSM moves to DATA.
- DATA shifts out bits 0..7, one per bit period, LSB first. A 3-bit counter tracks the bit; after bit 7 the FSM moves to STOP.
- STOP drives `tx`=1 for one bit period. At the end of STOP the FSM applies the IDLE pop condition in the same cycle:
  - If it holds, the FSM pops and goes straight to START, so frames are back-to-back with no extra idle time.
  - Otherwise it goes to IDLE.
- Bit period: a down-counter is loaded at the start of each bit with `max(div_int,1) + carry`. Here `carry` is the carry-out of `acc + div_frac`, where `acc` is a DIV_FRAC_W-bit accumulator that updates at each bit start. `acc` is cleared on entry to IDLE.
- `div_int` and `div_frac` are sampled at each bit start. Changing them mid-frame affects only subsequent bits.
- Deasserting `enable` mid-frame does not abort the frame; the current frame completes. No new pop occurs while `enable` is low.
- A simultaneous push and pop leaves `level` unchanged, and the pushed data is preserved. A push to an empty FIFO can be popped on the following cycle.
- Asserting reset mid-frame aborts the frame immediately. `tx` returns high asynchronously, and the FIFO contents are discarded.

## Timing
- Reset values:
  - `tx`=1
  - `wready`=1
  - `level`=0
  - `busy`=0
  - FSM=IDLE
  - `acc`=0
  - FIFO pointers 0
- `level` and `wready` are registered-count based and update the cycle after a handshake.
- Write-to-start-bit latency from empty and idle: a write accepted on edge N is popped on edge N+1, and `tx` falls after edge N+2.
- Each bit lasts exactly `max(div_int,1)+carry` cycles. A frame is 10 bit periods.
- `busy` is combinational: `(state != IDLE) || (level != 0)`.
- `tx` is driven from a flop, so it is glitch-free.

## Configuration
- `UART_TX_CTS_EN` defined: the `cts_n` port exists.
  - A pop (from IDLE or at the end of STOP) additionally requires `cts_n`=0.
  - `cts_n` is passed through a 2-flop synchroniser (reset value 1, meaning not clear) before use.
  - Deasserting `cts_n` mid-frame does not abort the frame.
- `UART_TX_CTS_EN` undefined: there is no `cts_n` port, no synchroniser, and the pop condition ignores flow control.

## Test plan
- Reset: hold `rst_n`=0 for 10 cycles -> `tx`=1, `wready`=1, `level`=0, `busy`=0 throughout and after release.
- Single byte:
  - Stimulus: `div_int`=434, `div_frac`=0, `enable`=1; write 0x55.
  - Required: `tx` falls 2 cycles after the accepting edge; the frame is 0,1,0,1,0,1,0,1,0,1 with each bit 434 cycles.
  - Required: the behavioural receiver at 115200 baud decodes 0x55.
- Fractional divider:
  - Stimulus: `div_int`=4, `div_frac`=8 (4.5 cycles/bit); send 0xA3.
  - Required: bit lengths alternate 4,5,4,5,…; total frame length 45 cycles.
- Full FIFO:
  - Stimulus: `enable`=0; write 9 bytes 0x00..0x08 with FIFO_DEPTH=8.
  - Required: `wready`=0 after the 8th write; the 9th write is dropped; `level`=8.
  - Then set `enable`=1. Required: bytes 0x00..0x07 are sent back-to-back with no idle cycles between stop and start bits.
- Mid-operation:
  - Stimulus: clear `enable` during bit 3 of a frame with 2 bytes queued. Required: the frame completes, `tx` stays high, `level`=2.
  - Then assert `rst_n`=0 mid-frame. Required: `tx`=1 immediately, `level`=0.
- CTS (UART_TX_CTS_EN): hold `cts_n`=1 and write 0x41 -> no start bit. Drop `cts_n` -> the start bit begins within 4 cycles and 0x41 is received.
